// File: rtl/i2c_slave.sv
// I2C target: oversamples sda/scl, detects START/STOP, matches ADDR, moves bytes to/from fabric.
// Latency: bus events seen 3 clk after the pin changes; rxvalid/txload are one-cycle strobes.
// Backpressure: rxready low at the 8th write bit NACKs the byte and parks in IGNORE; scl is never stretched.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sda             open-drain data (driven 0 or released), scl input from master
//   rxdata/rxvalid  last written byte and its strobe; rxready gates acceptance
//   txdata/txload   byte to return on reads and the strobe marking its capture
//   addressed, rw, busy, state   transaction status and FSM debug
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  input  logic       scl,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  input  logic       rxready,
  input  logic [7:0] txdata,
  output logic       txload,
  output logic       addressed,
  output logic       rw,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_WRITE_ACK = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_ACK  = 3'd6;
  localparam logic [2:0] S_IGNORE    = 3'd7;

  // [0],[1] synchronize, [2] is the previous synced value for edge detect
  logic [2:0] sda_sync;
  logic [2:0] scl_sync;
  logic       sda_s;
  logic       scl_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda_rise;
  logic       sda_fall;
  logic       start_cond;
  logic       stop_cond;

  logic       drive_low;
  logic [2:0] cnt;
  logic [6:0] sreg;      // bits shifted in so far; the 8th bit is taken directly from sda_s
  logic [6:0] txsreg;    // remaining read bits, next one to present in [6]
  logic       ack_phase; // second half of an ack slot (or ack already sampled on read)
  logic       ack_ok;    // rxready as seen at the 8th write bit

  assign sda = drive_low ? 1'b0 : 1'bz;

  assign sda_s      = sda_sync[1];
  assign scl_s      = scl_sync[1];
  assign scl_rise   =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall   = ~scl_sync[1] &  scl_sync[2];
  assign sda_rise   =  sda_sync[1] & ~sda_sync[2];
  assign sda_fall   = ~sda_sync[1] &  sda_sync[2];
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      // idle bus level, so leaving reset produces no spurious edges
      sda_sync <= 3'b111;
      scl_sync <= 3'b111;
    end else begin
      sda_sync <= {sda_sync[1:0], sda};
      scl_sync <= {scl_sync[1:0], scl};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      drive_low <= 1'b0;
      rxdata    <= 8'h00;
      rxvalid   <= 1'b0;
      txload    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 3'd7;
      sreg      <= 7'h00;
      txsreg    <= 7'h00;
      ack_phase <= 1'b0;
      ack_ok    <= 1'b0;
    end else begin
      rxvalid <= 1'b0;
      txload  <= 1'b0;
      if (start_cond) begin
        state     <= S_ADDR;
        busy      <= 1'b1;
        addressed <= 1'b0;
        cnt       <= 3'd7;
        drive_low <= 1'b0;
        ack_phase <= 1'b0;
      end else if (stop_cond) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        addressed <= 1'b0;
        drive_low <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            drive_low <= 1'b0;
          end

          S_ADDR: begin
            if (scl_rise) begin
              sreg <= {sreg[5:0], sda_s};
              if (cnt == 3'd0) begin
                // sreg now holds address bits [7:1], sda_s is R/W
                if (sreg == ADDR) begin
                  rw        <= sda_s;
                  ack_phase <= 1'b0;
                  state     <= S_ADDR_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                cnt <= cnt - 3'd1;
              end
            end
          end

          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                drive_low <= 1'b1;
                addressed <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= 3'd7;
                if (rw) begin
                  txsreg    <= txdata[6:0];
                  txload    <= 1'b1;
                  drive_low <= ~txdata[7];
                  state     <= S_READ;
                end else begin
                  drive_low <= 1'b0;
                  state     <= S_WRITE;
                end
              end
            end
          end

          S_WRITE: begin
            if (scl_rise) begin
              sreg <= {sreg[5:0], sda_s};
              if (cnt == 3'd0) begin
                ack_ok    <= rxready;
                ack_phase <= 1'b0;
                state     <= S_WRITE_ACK;
                if (rxready) begin
                  rxdata  <= {sreg, sda_s};
                  rxvalid <= 1'b1;
                end
              end else begin
                cnt <= cnt - 3'd1;
              end
            end
          end

          S_WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                drive_low <= ack_ok;
                ack_phase <= 1'b1;
              end else begin
                drive_low <= 1'b0;
                ack_phase <= 1'b0;
                cnt       <= 3'd7;
                state     <= ack_ok ? S_WRITE : S_IGNORE;
              end
            end
          end

          S_READ: begin
            if (scl_fall) begin
              if (cnt == 3'd0) begin
                // bit0 finished: release for the master's ack slot
                drive_low <= 1'b0;
                ack_phase <= 1'b0;
                state     <= S_READ_ACK;
              end else begin
                drive_low <= ~txsreg[6];
                txsreg    <= {txsreg[5:0], 1'b0};
                cnt       <= cnt - 3'd1;
              end
            end
          end

          S_READ_ACK: begin
            if (scl_rise && !ack_phase) begin
              if (sda_s) begin
                state <= S_IGNORE;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              txsreg    <= txdata[6:0];
              txload    <= 1'b1;
              drive_low <= ~txdata[7];
              cnt       <= 3'd7;
              state     <= S_READ;
            end
          end

          S_IGNORE: begin
            drive_low <= 1'b0;
          end

          default: begin
            drive_low <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, pull-up on sda, immediate-assertion checks.
module tb_i2c_slave;

  localparam int Q = 200; // quarter of an scl bit: 20 clk, scl period 80 clk

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic       rxready;
  logic [7:0] txdata;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       txload;
  logic       addressed;
  logic       rw;
  logic       busy;
  logic [2:0] state;
  wire        sda;

  int n_chk;
  int n_fail;
  int rxv_cnt;
  int txl_cnt;
  int slave_low_cnt;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk       (clk),
    .reset     (reset),
    .sda       (sda),
    .scl       (scl),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .rxready   (rxready),
    .txdata    (txdata),
    .txload    (txload),
    .addressed (addressed),
    .rw        (rw),
    .busy      (busy),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running event monitors; the stimulus compares deltas against baselines
  initial begin
    rxv_cnt = 0;
    txl_cnt = 0;
    slave_low_cnt = 0;
  end
  always @(negedge clk) begin
    if (rxvalid) rxv_cnt++;
    if (txload) txl_cnt++;
    if (sda === 1'b0 && !m_low) slave_low_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    ack   = (sda === 1'b0);
    #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic read_byte(output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #Q;
      scl   = 1'b1; #Q;
      b[i]  = (sda === 1'b1);
      #Q;
      scl   = 1'b0; #Q;
    end
  endtask

  logic       ack;
  logic [7:0] rd;
  int         base_rx;
  int         base_tx;
  int         base_low;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    scl     = 1'b1;
    m_low   = 1'b0;
    rxready = 1'b1;
    txdata  = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_rxdata", rxdata, 8'h00);
    chk("rst_rxvalid", {7'd0, rxvalid}, 8'd0);
    chk("rst_txload", {7'd0, txload}, 8'd0);
    chk("rst_addressed", {7'd0, addressed}, 8'd0);
    chk("rst_rw", {7'd0, rw}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_sda", {7'd0, sda}, 8'd1);

    // write one byte
    base_rx = rxv_cnt;
    i2c_start();
    chk("wr_busy", {7'd0, busy}, 8'd1);
    write_byte(8'hA0, ack);
    chk("wr_addr_ack", {7'd0, ack}, 8'd1);
    chk("wr_addressed", {7'd0, addressed}, 8'd1);
    chk("wr_rw", {7'd0, rw}, 8'd0);
    write_byte(8'h3C, ack);
    chk("wr_data_ack", {7'd0, ack}, 8'd1);
    chk("wr_state", {5'd0, state}, 8'd3);
    i2c_stop();
    @(negedge clk);
    chk("wr_rxvalid_cnt", 8'(rxv_cnt - base_rx), 8'd1);
    chk("wr_rxdata", rxdata, 8'h3C);
    chk("wr_addressed_stop", {7'd0, addressed}, 8'd0);
    chk("wr_busy_stop", {7'd0, busy}, 8'd0);
    chk("wr_state_stop", {5'd0, state}, 8'd0);

    // address mismatch
    base_rx  = rxv_cnt;
    base_low = slave_low_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    chk("mm_addr_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h55, ack);
    chk("mm_data_ack", {7'd0, ack}, 8'd0);
    chk("mm_state", {5'd0, state}, 8'd7);
    i2c_stop();
    @(negedge clk);
    chk("mm_state_stop", {5'd0, state}, 8'd0);
    chk("mm_sda_low_cycles", 8'(slave_low_cnt - base_low), 8'd0);
    chk("mm_rxvalid_cnt", 8'(rxv_cnt - base_rx), 8'd0);
    chk("mm_rxdata", rxdata, 8'h3C);

    // read two bytes, ACK then NACK
    base_tx = txl_cnt;
    txdata  = 8'h96;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rd_addr_ack", {7'd0, ack}, 8'd1);
    chk("rd_rw", {7'd0, rw}, 8'd1);
    txdata = 8'h0F;
    read_byte(rd);
    chk("rd_byte0", rd, 8'h96);
    send_bit(1'b0);
    read_byte(rd);
    chk("rd_byte1", rd, 8'h0F);
    send_bit(1'b1);
    @(negedge clk);
    chk("rd_state_nack", {5'd0, state}, 8'd7);
    chk("rd_sda_released", {7'd0, sda}, 8'd1);
    i2c_stop();
    @(negedge clk);
    chk("rd_txload_cnt", 8'(txl_cnt - base_tx), 8'd2);
    chk("rd_state_stop", {5'd0, state}, 8'd0);

    // repeated START: write then read
    base_rx = rxv_cnt;
    base_tx = txl_cnt;
    txdata  = 8'h5A;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("rs_addr0_ack", {7'd0, ack}, 8'd1);
    write_byte(8'h10, ack);
    chk("rs_data_ack", {7'd0, ack}, 8'd1);
    i2c_start();
    chk("rs_addressed_cleared", {7'd0, addressed}, 8'd0);
    chk("rs_state_addr", {5'd0, state}, 8'd1);
    write_byte(8'hA1, ack);
    chk("rs_addr1_ack", {7'd0, ack}, 8'd1);
    chk("rs_rw", {7'd0, rw}, 8'd1);
    read_byte(rd);
    chk("rs_rd_byte", rd, 8'h5A);
    send_bit(1'b1);
    i2c_stop();
    @(negedge clk);
    chk("rs_rxdata", rxdata, 8'h10);
    chk("rs_rxvalid_cnt", 8'(rxv_cnt - base_rx), 8'd1);
    chk("rs_txload_cnt", 8'(txl_cnt - base_tx), 8'd1);

    // rxready low: byte NACKed and dropped
    base_rx = rxv_cnt;
    rxready = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("nr_addr_ack", {7'd0, ack}, 8'd1);
    write_byte(8'h77, ack);
    chk("nr_data_ack", {7'd0, ack}, 8'd0);
    chk("nr_state", {5'd0, state}, 8'd7);
    send_bit(1'b1);
    chk("nr_state_hold", {5'd0, state}, 8'd7);
    chk("nr_rxvalid_cnt", 8'(rxv_cnt - base_rx), 8'd0);
    chk("nr_rxdata", rxdata, 8'h10);
    i2c_stop();
    @(negedge clk);
    chk("nr_state_stop", {5'd0, state}, 8'd0);
    rxready = 1'b1;

    // reset while slave holds sda low during a read (txdata bit7 = 0)
    txdata = 8'h00;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("mr_addr_ack", {7'd0, ack}, 8'd1);
    @(negedge clk);
    chk("mr_sda_held", {7'd0, sda}, 8'd0);
    chk("mr_state_read", {5'd0, state}, 8'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_sda_released", {7'd0, sda}, 8'd1);
    chk("mr_state", {5'd0, state}, 8'd0);
    chk("mr_busy", {7'd0, busy}, 8'd0);
    chk("mr_addressed", {7'd0, addressed}, 8'd0);
    chk("mr_rw", {7'd0, rw}, 8'd0);
    chk("mr_rxdata", rxdata, 8'h00);
    reset = 1'b0;
    scl   = 1'b1;
    #(2*Q);
    @(negedge clk);
    chk("mr_state_after", {5'd0, state}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
